// File: rtl/edge_pkg.sv
`default_nettype none
// ============================================================================
// Package  : edge_pkg
// Purpose  : Shared constants and state encoding for the edge-scan sequencer.
// Revision : 1.0
// ============================================================================
package edge_pkg;

  localparam int KWIN  = 9;
  localparam int PIX_W = 8;

  localparam logic MODE_PREWITT = 1'b0;
  localparam logic MODE_SOBEL   = 1'b1;

  typedef logic [3:0] state_t;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_SELECT = 4'd1;
  localparam logic [3:0] ST_BORDER = 4'd2;
  localparam logic [3:0] ST_FETCH  = 4'd3;
  localparam logic [3:0] ST_ISSUE  = 4'd4;
  localparam logic [3:0] ST_WAIT   = 4'd5;
  localparam logic [3:0] ST_WRITE  = 4'd6;
  localparam logic [3:0] ST_NEXT   = 4'd7;
  localparam logic [3:0] ST_DONE   = 4'd8;

endpackage
`default_nettype wire

// File: rtl/edge_win_fetch.sv
`default_nettype none
// ============================================================================
// Module   : edge_win_fetch
// Purpose  : Issues the 9 reads of a 3x3 window around a centre address and
//            assembles the returned pixels into the window register.
// Revision : 1.0
// ============================================================================
module edge_win_fetch
  import edge_pkg::*;
#(
  parameter int WIDTH  = 45,
  parameter int ADDR_W = 19
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go_i,
  input  logic [ADDR_W-1:0]     centre_i,
  input  logic [PIX_W-1:0]      rd_data_i,
  output logic                  rd_en_o,
  output logic [ADDR_W-1:0]     rd_addr_o,
  output logic [KWIN*PIX_W-1:0] win_o,
  output logic                  last_o
);

  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(WIDTH);
  localparam logic [3:0]        N_LAST   = 4'(KWIN);

  logic                  active_q, active_d;
  logic [3:0]            n_q, n_d;
  logic [1:0]            col_q, col_d;
  logic [ADDR_W-1:0]     row_q, row_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d;
  logic [KWIN*PIX_W-1:0] win_q, win_d;

  // Step n drives read n (n<=8) and captures the data of read n-1 (n>=1).
  always_comb begin
    active_d  = active_q;
    n_d       = n_q;
    col_d     = col_q;
    row_d     = row_q;
    rd_en_d   = rd_en_q;
    rd_addr_d = rd_addr_q;
    win_d     = win_q;
    if (go_i) begin
      active_d  = 1'b1;
      n_d       = 4'd0;
      col_d     = 2'd0;
      row_d     = centre_i - ROW_STEP - ADDR_W'(1);
      rd_addr_d = centre_i - ROW_STEP - ADDR_W'(1);
      rd_en_d   = 1'b1;
    end else if (active_q) begin
      for (int k = 0; k < KWIN; k++) begin
        if (n_q == 4'(k + 1)) begin
          win_d[k*PIX_W +: PIX_W] = rd_data_i;
        end
      end
      if (n_q < N_LAST - 4'd1) begin
        if (col_q == 2'd2) begin
          col_d     = 2'd0;
          row_d     = row_q + ROW_STEP;
          rd_addr_d = row_q + ROW_STEP;
        end else begin
          col_d     = col_q + 2'd1;
          rd_addr_d = rd_addr_q + ADDR_W'(1);
        end
      end else begin
        rd_en_d = 1'b0;
      end
      if (n_q == N_LAST) begin
        active_d = 1'b0;
      end
      n_d = n_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_q  <= 1'b0;
      n_q       <= 4'd0;
      col_q     <= 2'd0;
      row_q     <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      win_q     <= '0;
    end else begin
      active_q  <= active_d;
      n_q       <= n_d;
      col_q     <= col_d;
      row_q     <= row_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      win_q     <= win_d;
    end
  end

  assign rd_en_o   = rd_en_q;
  assign rd_addr_o = rd_addr_q;
  assign win_o     = win_q;
  assign last_o    = active_q && (n_q == N_LAST);

endmodule
`default_nettype wire

// File: rtl/edge_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : edge_scan_ctrl
// Purpose  : Raster-scan sequencer: zero-writes border pixels, fetches each
//            interior 3x3 window for the kernel engine and writes its result.
// Revision : 1.0
// ============================================================================
module edge_scan_ctrl
  import edge_pkg::*;
#(
  parameter int WIDTH  = 45,
  parameter int HEIGHT = 45,
  parameter int ADDR_W = 19
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode_in,
  output logic                  busy,
  output logic                  done,
  output logic                  kern_mode,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [PIX_W-1:0]      rd_data,
  output logic                  win_valid,
  output logic [KWIN*PIX_W-1:0] win_data,
  input  logic                  k_ready,
  input  logic                  pix_valid,
  input  logic [PIX_W-1:0]      pix_in,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [PIX_W-1:0]      wr_data
);

  localparam int ROW_W = $clog2(HEIGHT);
  localparam int COL_W = $clog2(WIDTH);
  localparam logic [ROW_W-1:0] R_MAX = ROW_W'(HEIGHT - 1);
  localparam logic [COL_W-1:0] C_MAX = COL_W'(WIDTH - 1);

  state_t            state_q, state_d;
  logic [ROW_W-1:0]  r_q, r_d;
  logic [COL_W-1:0]  c_q, c_d;
  logic [ADDR_W-1:0] pix_q, pix_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              kern_mode_q, kern_mode_d;
  logic              win_valid_q, win_valid_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [PIX_W-1:0]  wr_data_q, wr_data_d;

  logic w_go;
  logic w_fetch_last;
  logic w_border;
  logic w_last_pix;

  assign w_border   = (r_q == '0) || (r_q == R_MAX) || (c_q == '0) || (c_q == C_MAX);
  assign w_last_pix = (r_q == R_MAX) && (c_q == C_MAX);

  edge_win_fetch #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_fetch (
    .clk       (clk),
    .rst       (rst),
    .go_i      (w_go),
    .centre_i  (pix_q),
    .rd_data_i (rd_data),
    .rd_en_o   (rd_en),
    .rd_addr_o (rd_addr),
    .win_o     (win_data),
    .last_o    (w_fetch_last)
  );

  // pix_q tracks r*WIDTH+c incrementally, so no multiplier is needed.
  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    c_d         = c_q;
    pix_d       = pix_q;
    busy_d      = busy_q;
    done_d      = done_q;
    kern_mode_d = kern_mode_q;
    win_valid_d = win_valid_q;
    wr_en_d     = wr_en_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    w_go        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          kern_mode_d = mode_in;
          r_d         = '0;
          c_d         = '0;
          pix_d       = '0;
          busy_d      = 1'b1;
          state_d     = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (w_border) begin
          wr_en_d   = 1'b1;
          wr_addr_d = pix_q;
          wr_data_d = '0;
          state_d   = ST_BORDER;
        end else begin
          w_go    = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_BORDER: begin
        wr_en_d = 1'b0;
        state_d = ST_NEXT;
      end
      ST_FETCH: begin
        if (w_fetch_last) begin
          win_valid_d = 1'b1;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (k_ready) begin
          win_valid_d = 1'b0;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (pix_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = pix_q;
          wr_data_d = pix_in;
          state_d   = ST_WRITE;
        end
      end
      ST_WRITE: begin
        wr_en_d = 1'b0;
        state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (w_last_pix) begin
          r_d     = '0;
          c_d     = '0;
          pix_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          pix_d = pix_q + ADDR_W'(1);
          if (c_q == C_MAX) begin
            c_d = '0;
            r_d = r_q + ROW_W'(1);
          end else begin
            c_d = c_q + COL_W'(1);
          end
          state_d = ST_SELECT;
        end
      end
      ST_DONE: begin
        done_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      r_q         <= '0;
      c_q         <= '0;
      pix_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      kern_mode_q <= MODE_PREWITT;
      win_valid_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      c_q         <= c_d;
      pix_q       <= pix_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      kern_mode_q <= kern_mode_d;
      win_valid_q <= win_valid_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign kern_mode = kern_mode_q;
  assign win_valid = win_valid_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_edge_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_edge_scan_ctrl
// Purpose  : Self-checking bench for edge_scan_ctrl (5x5 and 3x3 instances).
// Revision : 1.0
// ============================================================================
module tb_edge_scan_ctrl;

  localparam int AW = 19;

  logic clk = 1'b0;
  logic rst;
  logic start_a, start_b, mode_in, k_ready;
  logic [7:0] eng_val;
  logic [7:0] mem [0:63];

  logic          a_busy, a_done, a_kmode, a_rd_en, a_win_valid, a_wr_en, a_pv;
  logic [AW-1:0] a_rd_addr, a_wr_addr;
  logic [7:0]    a_rd_data, a_wr_data;
  logic [71:0]   a_win;
  logic          b_busy, b_done, b_kmode, b_rd_en, b_win_valid, b_wr_en, b_pv;
  logic [AW-1:0] b_rd_addr, b_wr_addr;
  logic [7:0]    b_rd_data, b_wr_data;
  logic [71:0]   b_win;

  always #5 clk = ~clk;

  edge_scan_ctrl #(.WIDTH(5), .HEIGHT(5), .ADDR_W(AW)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .mode_in(mode_in),
    .busy(a_busy), .done(a_done), .kern_mode(a_kmode),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
    .win_valid(a_win_valid), .win_data(a_win), .k_ready(k_ready),
    .pix_valid(a_pv), .pix_in(eng_val),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data)
  );

  edge_scan_ctrl #(.WIDTH(3), .HEIGHT(3), .ADDR_W(AW)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .mode_in(mode_in),
    .busy(b_busy), .done(b_done), .kern_mode(b_kmode),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .win_valid(b_win_valid), .win_data(b_win), .k_ready(k_ready),
    .pix_valid(b_pv), .pix_in(eng_val),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data)
  );

  // Pixel memory (1-cycle read latency) and engine (result 1 cycle after accept).
  always @(posedge clk) begin
    a_pv <= a_win_valid & k_ready;
    b_pv <= b_win_valid & k_ready;
    if (a_rd_en) a_rd_data <= mem[a_rd_addr[5:0]];
    if (b_rd_en) b_rd_data <= mem[b_rd_addr[5:0]];
  end

  logic sel;
  wire          m_busy      = sel ? b_busy      : a_busy;
  wire          m_done      = sel ? b_done      : a_done;
  wire          m_kmode     = sel ? b_kmode     : a_kmode;
  wire          m_rd_en     = sel ? b_rd_en     : a_rd_en;
  wire [AW-1:0] m_rd_addr   = sel ? b_rd_addr   : a_rd_addr;
  wire          m_win_valid = sel ? b_win_valid : a_win_valid;
  wire [71:0]   m_win       = sel ? b_win       : a_win;
  wire          m_wr_en     = sel ? b_wr_en     : a_wr_en;
  wire [AW-1:0] m_wr_addr   = sel ? b_wr_addr   : a_wr_addr;
  wire [7:0]    m_wr_data   = sel ? b_wr_data   : a_wr_data;

  int n_tests, n_fail;
  int rd_cnt, wr_cnt, done_cnt, busy_cyc;
  bit mon_en, exp_mode, pend;
  logic [71:0]   last_win;
  logic [AW-1:0] q_rd[$];
  logic [AW-1:0] q_wa[$];
  logic [7:0]    q_wd[$];
  logic [71:0]   q_win[$];

  task automatic chk(input string name, input logic [71:0] got, input logic [71:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: unexpected event, nothing expected", name);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Model: raster order, border -> 0, interior -> 9 row-major reads then engine value.
  task automatic build_model(input int w, input int h, input bit m, input logic [7:0] v);
    logic [71:0] win;
    q_rd.delete(); q_wa.delete(); q_wd.delete(); q_win.delete();
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0; busy_cyc = 0; pend = 0;
    exp_mode = m; eng_val = v; win = '0;
    for (int p = 0; p < w * h; p++) begin
      int r, c;
      r = p / w;
      c = p % w;
      q_wa.push_back(AW'(p));
      if (r == 0 || r == h - 1 || c == 0 || c == w - 1) begin
        q_wd.push_back(8'h00);
      end else begin
        for (int k = 0; k < 9; k++) begin
          int a;
          a = (r - 1 + k / 3) * w + (c - 1 + k % 3);
          q_rd.push_back(AW'(a));
          win[8*k +: 8] = mem[a];
        end
        q_win.push_back(win);
        q_wd.push_back(v);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (m_rd_en) begin
        rd_cnt++;
        if (q_rd.size() == 0) flag_fail("rd_extra");
        else chk("rd_addr", 72'(m_rd_addr), 72'(q_rd.pop_front()));
      end
      if (m_wr_en) begin
        wr_cnt++;
        if (q_wa.size() == 0) flag_fail("wr_extra");
        else begin
          chk("wr_addr", 72'(m_wr_addr), 72'(q_wa.pop_front()));
          chk("wr_data", 72'(m_wr_data), 72'(q_wd.pop_front()));
        end
      end
      if (pend) begin
        chk("win_hold_valid", 72'(m_win_valid), 72'(1));
        chk("win_hold_data", m_win, last_win);
      end
      if (m_win_valid && k_ready) begin
        if (q_win.size() == 0) flag_fail("win_extra");
        else chk("win_data", m_win, q_win.pop_front());
      end
      pend     = m_win_valid && !k_ready;
      last_win = m_win;
      if (m_busy) begin
        busy_cyc++;
        chk("kern_mode", 72'(m_kmode), 72'(exp_mode));
      end
      if (m_done) begin
        done_cnt++;
        chk("done_while_busy", 72'(m_busy), 72'(0));
      end
    end
  end

  task automatic start_frame(input bit which, input bit m);
    if (which) start_b = 1'b1; else start_a = 1'b1;
    mode_in = m;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int d0;
    bit ok;
    d0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (done_cnt != d0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("done_timeout", 72'(ok), 72'(1));
  endtask

  task automatic end_frame(input int nwr);
    chk("wr_count", 72'(wr_cnt), 72'(nwr));
    chk("done_count", 72'(done_cnt), 72'(1));
    chk("rd_left", 72'(q_rd.size()), 72'(0));
    chk("wr_left", 72'(q_wa.size()), 72'(0));
    chk("win_left", 72'(q_win.size()), 72'(0));
    repeat (3) tick();
    chk("idle_after", 72'({m_busy, m_done}), 72'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lit5 [9];
    int ni;
    bit found;
    logic [71:0] snap;
    lit5 = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    n_tests = 0; n_fail = 0; mon_en = 0; sel = 0;
    start_a = 0; start_b = 0; mode_in = 0; k_ready = 1; eng_val = 0;
    for (int i = 0; i < 64; i++) mem[i] = 8'((i * 37 + 11) & 255);

    // Reset: outputs all zero, then idle with no start.
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    chk("rst_ctrl_a", 72'({a_busy, a_done, a_kmode, a_rd_en, a_win_valid, a_wr_en}), 72'(0));
    chk("rst_addr_a", 72'({a_rd_addr, a_wr_addr, a_wr_data}), 72'(0));
    chk("rst_win_a", a_win, 72'(0));
    chk("rst_ctrl_b", 72'({b_busy, b_done, b_kmode, b_rd_en, b_win_valid, b_wr_en}), 72'(0));
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_busy", 72'(a_busy), 72'(0));
    end

    // Frame 1: 5x5 Sobel, no stall.
    build_model(5, 5, 1'b1, 8'hA5);
    for (int k = 0; k < 9; k++) chk("model_rd5", 72'(q_rd[k]), 72'(lit5[k]));
    ni = 0;
    foreach (q_wd[i]) if (q_wd[i] == 8'hA5) ni++;
    chk("model_interior", 72'(ni), 72'(9));
    chk("model_wd6", 72'(q_wd[6]), 72'(8'hA5));
    chk("model_wd5", 72'(q_wd[5]), 72'(0));
    mon_en = 1;
    start_frame(1'b0, 1'b1);
    wait_done(400);
    chk("busy_cycles5", 72'(busy_cyc), 72'(183));
    end_frame(25);
    chk("kern_mode_held", 72'(a_kmode), 72'(1));

    // Frame 2: Prewitt, backpressure on first window, restart attempts while busy.
    build_model(5, 5, 1'b0, 8'h3C);
    k_ready = 1'b0;
    start_frame(1'b0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (a_win_valid) begin
        found = 1'b1;
        break;
      end
    end
    chk("bp_reach", 72'(found), 72'(1));
    snap = a_win;
    repeat (5) begin
      tick();
      chk("bp_valid", 72'(a_win_valid), 72'(1));
      chk("bp_data", a_win, snap);
    end
    k_ready = 1'b1;
    tick();
    chk("bp_accept", 72'(a_win_valid), 72'(0));
    start_a = 1'b1; mode_in = 1'b1;
    repeat (3) tick();
    start_a = 1'b0; mode_in = 1'b0;
    wait_done(600);
    end_frame(25);

    // Frame 3: reset during the 5th read of pixel 6.
    build_model(5, 5, 1'b1, 8'h5A);
    start_frame(1'b0, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (rd_cnt == 4 && a_rd_en) begin
        found = 1'b1;
        break;
      end
    end
    chk("abort_reach", 72'(found), 72'(1));
    chk("abort_rd_addr", 72'(a_rd_addr), 72'(6));
    mon_en = 0;
    rst = 1'b0;
    #1;
    chk("abort_drop", 72'({a_rd_en, a_wr_en, a_busy, a_win_valid, a_done}), 72'(0));
    repeat (2) tick();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("abort_quiet", 72'({a_rd_en, a_wr_en, a_done, a_busy}), 72'(0));
    end

    // Frame 4: full frame after abort.
    build_model(5, 5, 1'b1, 8'hC3);
    mon_en = 1;
    start_frame(1'b0, 1'b1);
    wait_done(400);
    end_frame(25);

    // Frame 5: 3x3 on the second instance.
    sel = 1'b1;
    build_model(3, 3, 1'b0, 8'h96);
    for (int k = 0; k < 9; k++) chk("model_rd3", 72'(q_rd[k]), 72'(k));
    chk("model_wd4", 72'(q_wd[4]), 72'(8'h96));
    start_frame(1'b1, 1'b0);
    wait_done(200);
    chk("busy_cycles3", 72'(busy_cyc), 72'(39));
    end_frame(9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/edge_scan_ctrl.md
# edge_scan_ctrl

Raster-scan sequencer for the 3x3 edge-detection datapath (Sobel/Prewitt kernel engine). It walks the image in pixel order and fetches each interior 3x3 window from pixel memory through a single read port. Each window goes to the kernel engine over a valid/ready handshake, and the engine's result is written to output memory. Border pixels are written as 0 without a fetch. It also latches the kernel mode for the engine and reports busy/done to the top-level test harness.

## Interface
- WIDTH, 45, image width in pixels (≥3)
- HEIGHT, 45, image height in pixels (≥3)
- ADDR_W, 19, address width; must hold WIDTH*HEIGHT-1
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  begin a frame; sampled only in IDLE
- mode_in  in  1  kernel select: 0 Prewitt, 1 Sobel; sampled with start
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse after the last write
- kern_mode  out  1  latched mode for the kernel engine
- rd_en  out  1  pixel-memory read strobe
- rd_addr  out  ADDR_W  read address
- rd_data  in  8  read data, valid exactly 1 cycle after rd_en
- win_valid  out  1  window presented
- win_data  out  72  9 pixels packed, slot 0 in bits [7:0], row-major
- k_ready  in  1  engine accepts window when win_valid&k_ready
- pix_valid  in  1  engine result valid (single-cycle)
- pix_in  in  8  engine result
- wr_en  out  1  output-memory write strobe
- wr_addr  out  ADDR_W  write address
- wr_data  out  8  write data

## Operation
- Reset: IDLE; busy, done, rd_en, win_valid, wr_en, kern_mode = 0; addresses and data = 0; row/col counters = 0.
- IDLE: start=1 latches kern_mode←mode_in, clears r=c=0, goes to SELECT. Start at any other time is ignored.
- SELECT: if r=0, r=HEIGHT-1, c=0 or c=WIDTH-1, go to BORDER; otherwise go to FETCH.
- BORDER: one cycle with wr_en=1, wr_addr=r*WIDTH+c, wr_data=0, then NEXT.
- FETCH: counter n=0..9. For n≤8: rd_en=1, rd_addr=(r-1+n/3)*WIDTH+(c-1+n%3). For n≥1: slot n-1 ← rd_data. After n=9, go to ISSUE.
- ISSUE: win_valid=1 with win_data stable until k_ready; the handshake cycle clears win_valid and moves to WAIT.
- WAIT: on pix_valid, one cycle with wr_en=1, wr_addr=r*WIDTH+c, wr_data=pix_in, then NEXT. pix_valid outside WAIT is ignored.
- NEXT: c++. When c wraps at WIDTH-1, c=0 and r++. After pixel WIDTH*HEIGHT-1, go to DONE; otherwise go to SELECT.
- DONE: done=1 for one cycle, busy drops the same cycle, then IDLE.
- Address arithmetic is unsigned ADDR_W. Interior-only fetch guarantees no under/overflow.
- Reset asserted mid-frame aborts immediately: no further rd_en/wr_en, no done. Outputs return to their reset values.

## Timing
- All outputs are registered.
- Border pixel: SELECT, BORDER, NEXT = 3 cycles per pixel.
- Interior pixel: SELECT (1), FETCH (10), ISSUE (≥1), WAIT (≥1), write (1), NEXT (1). This is 15 cycles with zero engine stall and pix_valid one cycle after acceptance.
- Exactly WIDTH*HEIGHT writes per frame, in strictly ascending addresses.
- Exactly 9 reads per interior pixel; no reads for border pixels.
- kern_mode is constant from start acceptance to done.

## Structure
- Package edge_pkg:
  - state enum (IDLE, SELECT, BORDER, FETCH, ISSUE, WAIT, WRITE, NEXT, DONE)
  - MODE_PREWITT=0, MODE_SOBEL=1
  - KWIN=9, PIX_W=8
- Sub-module edge_win_fetch: 9-read address generator plus window register. Interface is go/centre address in, window/valid out. The top-level FSM, counters and write port stay in edge_scan_ctrl.

## Test plan
- Reset, with rst low for 3 cycles then high and no start → every output 0; busy stays 0 for 20 cycles.
- 5x5 frame, mode_in=1, k_ready=1, engine returns 8'hA5 one cycle after accept:
  - 25 writes to addresses 0..24 in order.
  - 16 border writes of 0; interior addresses 6,7,8,11,12,13,16,17,18 get A5.
  - First fetch reads 0,1,2,5,6,7,10,11,12.
  - kern_mode=1 throughout; one done pulse.
- Backpressure: k_ready held low 5 cycles in ISSUE → win_valid stays 1 and win_data unchanged; acceptance occurs on the cycle k_ready rises.
- Start pulse and mode_in toggled while busy → no restart, kern_mode unchanged, write count still 25.
- Reset asserted at FETCH n=4 of pixel 6 → rd_en/wr_en drop immediately, no done. A new start then completes a full frame of 25 writes.
- 3x3 frame → 8 border writes of 0, one interior write at address 4 after reads 0..8 in order; done follows.
